// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory address/data, IF/ID register and perf counters.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface fetch_if #(
  parameter int N = 32
);
  logic         stall;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         jump;
  logic [25:0]  jump_target;
  logic [N-1:0] instruction_in;
  logic [N-1:0] memory_address;
  logic [N-1:0] if_id_instruction;
  logic [N-1:0] if_id_pc_plus1;
  logic         if_id_valid;
  logic [31:0]  perf_fetch_count;
  logic [31:0]  perf_stall_count;
  logic [31:0]  perf_flush_count;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, instruction_in,
    output memory_address, if_id_instruction, if_id_pc_plus1, if_id_valid,
    output perf_fetch_count, perf_stall_count, perf_flush_count
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, instruction_in,
    input  memory_address, if_id_instruction, if_id_pc_plus1, if_id_valid,
    input  perf_fetch_count, perf_stall_count, perf_flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: word-addressed PC, IF/ID register, stall and branch/jump redirect with one bubble.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters; otherwise those ports read 0.
module fetch_stage #(
  parameter int N          = 32,
  parameter int IMEM_DEPTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam logic [N-1:0] PC_MASK = N'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } action_e;

  action_e      action_s;
  logic [N-1:0] pc_r;
  logic [N-1:0] pc_plus1_s;
  logic [N-1:0] next_pc_s;
  logic [N-1:0] instr_r;
  logic [N-1:0] pc_plus1_r;
  logic         valid_r;

  // Edge action and next PC; branch beats jump beats stall.
  always_comb begin
    pc_plus1_s = (pc_r + N'(1)) & PC_MASK;
    action_s   = ACT_ADVANCE;
    next_pc_s  = pc_plus1_s;
    if (bus.branch_taken) begin
      action_s  = ACT_REDIRECT;
      next_pc_s = bus.branch_target & PC_MASK;
    end else if (bus.jump) begin
      action_s  = ACT_REDIRECT;
      next_pc_s = {pc_r[N-1:26], bus.jump_target} & PC_MASK;
    end else if (bus.stall) begin
      action_s  = ACT_STALL;
      next_pc_s = pc_r;
    end else begin
      action_s  = ACT_ADVANCE;
      next_pc_s = pc_plus1_s;
    end
  end

  // PC and IF/ID pipeline register; a redirect loads an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= {N{1'b0}};
      instr_r    <= {N{1'b0}};
      pc_plus1_r <= {N{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      pc_r <= next_pc_s;
      case (action_s)
        ACT_ADVANCE: begin
          instr_r    <= bus.instruction_in;
          pc_plus1_r <= pc_plus1_s;
          valid_r    <= 1'b1;
        end
        ACT_REDIRECT: begin
          instr_r    <= {N{1'b0}};
          pc_plus1_r <= {N{1'b0}};
          valid_r    <= 1'b0;
        end
        ACT_STALL: begin
          instr_r    <= instr_r;
          pc_plus1_r <= pc_plus1_r;
          valid_r    <= valid_r;
        end
        default: begin
          instr_r    <= {N{1'b0}};
          pc_plus1_r <= {N{1'b0}};
          valid_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memory_address    = pc_r;
  assign bus.if_id_instruction = instr_r;
  assign bus.if_id_pc_plus1    = pc_plus1_r;
  assign bus.if_id_valid       = valid_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

  // One counter per edge action, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      case (action_s)
        ACT_ADVANCE:  fetch_cnt_r <= sat_inc(fetch_cnt_r);
        ACT_STALL:    stall_cnt_r <= sat_inc(stall_cnt_r);
        ACT_REDIRECT: flush_cnt_r <= sat_inc(flush_cnt_r);
        default:      fetch_cnt_r <= fetch_cnt_r;
      endcase
    end
  end

  assign bus.perf_fetch_count = fetch_cnt_r;
  assign bus.perf_stall_count = stall_cnt_r;
  assign bus.perf_flush_count = flush_cnt_r;
`else
  assign bus.perf_fetch_count = 32'd0;
  assign bus.perf_stall_count = 32'd0;
  assign bus.perf_flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected IF state, a monitor pops and compares after each edge.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc1;
    logic        valid;
    logic [31:0] fcnt;
    logic [31:0] scnt;
    logic [31:0] flcnt;
  } exp_t;

  logic clk;
  logic reset;
  fetch_if #(.N(32)) bus ();

  fetch_stage #(.N(32), .IMEM_DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  exp_t q[$];
  int   checks;
  int   errors;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  function automatic logic [31:0] word(input logic [31:0] addr);
    return 32'hA500_0000 | {27'd0, addr[4:0]};
  endfunction

  // Instruction memory: 32 distinct combinational words.
  assign bus.instruction_in = word(bus.memory_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [25:0] jt,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc1, input logic e_valid);
    exp_t e;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
`ifdef FETCH_PERF_CNT_EN
    if (br || j) m_flush = m_flush + 32'd1;
    else if (st) m_stall = m_stall + 32'd1;
    else         m_fetch = m_fetch + 32'd1;
`endif
    e.addr  = e_addr;
    e.instr = e_instr;
    e.pc1   = e_pc1;
    e.valid = e_valid;
    e.fcnt  = m_fetch;
    e.scnt  = m_stall;
    e.flcnt = m_flush;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic norm(input int p);
    step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'((p + 1) % 32), word(32'(p)), 32'((p + 1) % 32), 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},  bus.memory_address,    32'd0);
    chk({tag, "_instr"}, bus.if_id_instruction, 32'd0);
    chk({tag, "_pc1"},   bus.if_id_pc_plus1,    32'd0);
    chk({tag, "_valid"}, {31'd0, bus.if_id_valid}, 32'd0);
    chk({tag, "_fcnt"},  bus.perf_fetch_count,  32'd0);
    chk({tag, "_scnt"},  bus.perf_stall_count,  32'd0);
    chk({tag, "_flcnt"}, bus.perf_flush_count,  32'd0);
  endtask

  // Monitor: compare the DUT against the oldest expectation one step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("addr",  bus.memory_address,    e.addr);
        chk("instr", bus.if_id_instruction, e.instr);
        chk("pc1",   bus.if_id_pc_plus1,    e.pc1);
        chk("valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        chk("fcnt",  bus.perf_fetch_count,  e.fcnt);
        chk("scnt",  bus.perf_stall_count,  e.scnt);
        chk("flcnt", bus.perf_flush_count,  e.flcnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    m_fetch = 32'd0;
    m_stall = 32'd0;
    m_flush = 32'd0;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump = 1'b0;
    bus.jump_target = 26'd0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b1;

    for (int p = 0; p < 5; p++) norm(p);
    repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd5, word(32'd4), 32'd5, 1'b1);
    for (int p = 5; p < 12; p++) norm(p);
    // Branch to 2 at PC=12, then target instruction.
    step(1'b0, 1'b1, 32'd2, 1'b0, 26'd0, 32'd2, 32'd0, 32'd0, 1'b0);
    norm(2);
    // Branch, jump and stall together: branch wins.
    step(1'b1, 1'b1, 32'd7, 1'b1, 26'd15, 32'd7, 32'd0, 32'd0, 1'b0);
    norm(7);
    step(1'b0, 1'b0, 32'd0, 1'b1, 26'd20, 32'd20, 32'd0, 32'd0, 1'b0);
    norm(20);
    // Jump beats stall.
    step(1'b1, 1'b0, 32'd0, 1'b1, 26'd30, 32'd30, 32'd0, 32'd0, 1'b0);
    norm(30);
    norm(31);
    step(1'b0, 1'b1, 32'd40, 1'b0, 26'd0, 32'd8, 32'd0, 32'd0, 1'b0);
    norm(8);
    step(1'b0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFE3, 32'd3, 32'd0, 32'd0, 1'b0);
    // Stall holds the bubble.
    step(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd3, 32'd0, 32'd0, 1'b0);
    norm(3);

    // Asynchronous reset in the middle of a stalled cycle.
    bus.stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_zero("async");
    bus.stall = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    m_fetch = 32'd0;
    m_stall = 32'd0;
    m_flush = 32'd0;
    norm(0);
    norm(1);

    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
